// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes, FSM states, default sizes.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 6;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } mdu_state_e;
endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned datapath: one shift-add (multiply) or restoring-subtract (divide) step per step_i.
// acc holds partial product high half / remainder; sh holds multiplier-then-low-half / dividend-then-quotient.
module mdu_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             last_o
);
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, m_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum, trial, diff;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, m_q};
    trial = {acc_q, sh_q[WIDTH-1]};
    diff  = trial - {1'b0, m_q};
    acc_d = acc_q;
    sh_d  = sh_q;
    if (div_i) begin
      // Remainder stays below the divisor, so the borrow bit decides restore vs keep.
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = trial[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else if (sh_q[0]) begin
      acc_d = sum[WIDTH:1];
      sh_d  = {sum[0], sh_q[WIDTH-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[WIDTH-1:1]};
      sh_d  = {acc_q[0], sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      sh_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= '0;
      sh_q  <= q_i;
      m_q   <= m_i;
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hi_o   = acc_q;
  assign lo_o   = sh_q;
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; single-cycle MTHI/MTLO.
// Optional MDU_ABORT_EN adds an abort input that flushes an in-flight op.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef MDU_ABORT_EN
  input  logic             abort,
`endif
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mdu_state_e       state_q, state_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, div_q, div_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             load, step, kill, last, sgn, is_mul, is_div;
  logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

`ifdef MDU_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign sgn    = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
  assign is_div = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign a_mag  = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag  = (sgn && B[WIDTH-1]) ? -B : B;

  assign prod     = {core_hi, core_lo};
  assign prod_fix = neg_q  ? -prod    : prod;
  assign q_fix    = neg_q  ? -core_lo : core_lo;
  assign r_fix    = rneg_q ? -core_hi : core_hi;

  mdu_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .step_i (step),
    .div_i  (state_q == DIV),
    .m_i    (is_div ? b_mag : a_mag),
    .q_i    (is_div ? a_mag : b_mag),
    .hi_o   (core_hi),
    .lo_o   (core_lo),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div_d   = div_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (start && !kill) begin
        if (is_mul || (is_div && B != '0)) begin
          load    = 1'b1;
          neg_d   = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
          rneg_d  = sgn && A[WIDTH-1];
          div_d   = is_div;
          state_d = is_div ? DIV : MUL;
        end else if (is_div) begin
          done_d = 1'b1;
          dbz_d  = 1'b1;
        end else if (op == MDU_MTHI) begin
          hi_d = A;
        end else if (op == MDU_MTLO) begin
          lo_d = A;
        end
      end
      MUL, DIV: begin
        step = 1'b1;
        if (last) state_d = FIXUP;
      end
      FIXUP: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          lo_d = q_fix;
          hi_d = r_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush beats everything else in flight, including the FIXUP write.
    if (kill && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div_q   <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div_q   <= div_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {dbz,hi,lo} pushed at issue, popped on done.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;
`ifdef MDU_ABORT_EN
  logic        abort;
`endif

  logic [64:0] sbq[$];
  logic [31:0] hi_m, lo_m;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef MDU_ABORT_EN
    .abort       (abort),
`endif
    .op          (op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .div_by_zero (dbz),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result {dbz, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a, b,
                                        input logic [31:0] h, l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    model = {1'b0, h, l};
    case (o)
      3'd0: begin q = sa * sb; model = {1'b0, q[63:0]}; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; model = {1'b0, p}; end
      3'd2: if (b == 0) model = {1'b1, h, l};
            else begin q = sa / sb; r = sa % sb; model = {1'b0, r[31:0], q[31:0]}; end
      3'd3: if (b == 0) model = {1'b1, h, l};
            else model = {1'b0, a % b, a / b};
      default: model = {1'b0, h, l};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, input int intr);
    logic [64:0] e;
    int edges, bcnt, both;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    sbq.push_back(model(o, a, b, hi_m, lo_m));
    @(negedge clk);
    start = 1'b0; edges = 1; bcnt = 0; both = 0;
    while (!done && edges < 100) begin
      if (busy) bcnt++;
      if (intr > 0 && edges == intr) begin start = 1'b1; op = 3'd5; A = 32'hDEAD; end
      if (intr > 0 && edges == intr + 1) start = 1'b0;
      @(negedge clk);
      edges++;
    end
    chk("done_seen", {63'b0, done}, 64'd1);
    chk("busy_with_done", {63'b0, busy}, 64'd0);
    e = sbq.pop_front();
    chk("hi", hi, e[63:32]);
    chk("lo", lo, e[31:0]);
    chk("dbz", {63'b0, dbz}, {63'b0, e[64]});
    chk("latency", edges, e[64] ? 64'd1 : 64'd34);
    chk("busy_cycles", bcnt, e[64] ? 64'd0 : 64'd33);
    hi_m = e[63:32];
    lo_m = e[31:0];
    @(negedge clk);
    chk("done_pulse", {62'b0, done, dbz}, 64'd0);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    op = o; A = a; start = 1'b1;
    if (o == 3'd4) hi_m = a;
    else if (o == 3'd5) lo_m = a;
    @(negedge clk);
    start = 1'b0;
    chk("mt_hilo", {hi, lo}, {hi_m, lo_m});
    chk("mt_flags", {62'b0, busy, done}, 64'd0);
  endtask

  task automatic kill_op(input bit use_abort);
    int dn;
    @(negedge clk);
    op = 3'd3; A = 32'h12345678; B = 32'h9; start = 1'b1;
    sbq.push_back(model(3'd3, A, B, hi_m, lo_m));
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    if (use_abort) begin
`ifdef MDU_ABORT_EN
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
`endif
      chk("abort_busy", {63'b0, busy}, 64'd0);
      chk("abort_hilo", {hi, lo}, {hi_m, lo_m});
    end else begin
      reset = 1'b1;
      #1;
      hi_m = '0; lo_m = '0;
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
    end
    void'(sbq.pop_back());
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no_done_after_kill", dn, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    hi_m = '0; lo_m = '0;
`ifdef MDU_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_flags", {61'b0, busy, done, dbz}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    run_mt(3'd4, 32'h11);
    run_mt(3'd5, 32'h22);
    run_op(3'd3, 32'd100, 32'd0, 0);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, 0);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'h10, 0);
    run_op(3'd2, 32'd5, 32'd0, 0);
    run_op(3'd1, 32'd5, 32'd6, 10);
    chk("intrude_lo", lo, 64'd30);

    // Reserved opcode must leave everything untouched.
    run_mt(3'd6, 32'hBAD0BAD0);
    run_mt(3'd7, 32'hBAD1BAD1);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) rb = rb >> 20;
      run_op(3'($urandom_range(0, 3)), ra, rb, 0);
    end

    run_mt(3'd4, 32'hCAFE0001);
    run_mt(3'd5, 32'hCAFE0002);
    kill_op(1'b0);

`ifdef MDU_ABORT_EN
    run_mt(3'd4, 32'h0000AAAA);
    run_mt(3'd5, 32'h0000BBBB);
    kill_op(1'b1);
    @(negedge clk);
    op = 3'd4; A = 32'h5555; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_blocks_mthi", {hi, lo}, {hi_m, lo_m});
`endif

    chk("sbq_empty", sbq.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
